// File: rtl/flit_eject.sv
// -----------------------------------------------------------------------------
// flit_eject
//   Destination-end ejector for the 10-bit router flit stream.
//   Each cycle one flit may arrive from a router output port. Flits whose
//   destination code matches LOCAL_DEST are captured into a DEPTH-entry FIFO
//   and handed to the local node over a valid/ready handshake. Every other
//   valid flit, and any local flit that finds the FIFO full, is re-emitted on
//   the pass port one cycle later so the router can deflect it.
//   Flit format: [9] golden bit, [8:6] destination code, [5:0] payload.
//
// Optional feature macro: EJECT_STATS_EN
//   When defined, adds the CNT_W parameter and the saturating statistics
//   outputs defl_cnt / ej_cnt. When undefined, those ports and counters are
//   absent and all other behaviour is unchanged.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_flit    in   10     flit from router output port
//   in_vld     in   1      in_flit valid (no backpressure)
//   pass_flit  out  10     registered flit returned to router
//   pass_vld   out  1      pass_flit valid
//   ej_flit    out  10     FIFO head flit to local node
//   ej_vld     out  1      FIFO non-empty (registered)
//   ej_rdy     in   1      local node accepts ej_flit
//   ej_full    out  1      FIFO holds DEPTH entries (registered)
//   defl_cnt   out  CNT_W  local flits deflected by a full FIFO (stats only)
//   ej_cnt     out  CNT_W  flits delivered to local node (stats only)
// -----------------------------------------------------------------------------
module flit_eject #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [2:0]  LOCAL_DEST = 3'b010
`ifdef EJECT_STATS_EN
  , parameter int unsigned CNT_W    = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       in_flit,
  input  logic             in_vld,
  output logic [9:0]       pass_flit,
  output logic             pass_vld,
  output logic [9:0]       ej_flit,
  output logic             ej_vld,
  input  logic             ej_rdy,
  output logic             ej_full
`ifdef EJECT_STATS_EN
  , output logic [CNT_W-1:0] defl_cnt,
  output logic [CNT_W-1:0] ej_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0][9:0] mem_q, mem_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  ej_vld_q, ej_vld_d;
  logic                  ej_full_q, ej_full_d;
  logic [9:0]            pass_flit_q, pass_flit_d;
  logic                  pass_vld_q, pass_vld_d;

  // ---------------------------------------------------------------------------
  // Flit classification
  // ---------------------------------------------------------------------------
  logic is_local;
  logic wr_en;
  logic pop_en;
  logic pass_en;

  assign is_local = in_vld && (in_flit[8:6] == LOCAL_DEST);
  // Only the registered full flag gates the write: a pop in this same cycle
  // does not make room, the flit is deflected instead. This keeps ej_rdy out
  // of the write-enable path.
  assign wr_en    = is_local && !ej_full_q;
  assign pop_en   = ej_vld_q && ej_rdy;
  assign pass_en  = in_vld && (!is_local || ej_full_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pass_flit_d = pass_flit_q;
    pass_vld_d  = pass_en;

    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = in_flit;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // pass_flit holds its last value when nothing is passed.
    if (pass_en) begin
      pass_flit_d = in_flit;
    end

    // Occupancy flags are registered from the next pointers, so ej_vld and
    // ej_full never have a combinational path from the inputs.
    ej_vld_d  = (wr_ptr_d != rd_ptr_d);
    ej_full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ej_vld_q    <= 1'b0;
      ej_full_q   <= 1'b0;
      pass_flit_q <= '0;
      pass_vld_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ej_vld_q    <= ej_vld_d;
      ej_full_q   <= ej_full_d;
      pass_flit_q <= pass_flit_d;
      pass_vld_q  <= pass_vld_d;
    end
  end

  assign pass_flit = pass_flit_q;
  assign pass_vld  = pass_vld_q;
  assign ej_vld    = ej_vld_q;
  assign ej_full   = ej_full_q;
  // Head is read straight from the array; no output register.
  assign ej_flit   = mem_q[rd_ptr_q[AW-1:0]];

`ifdef EJECT_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics counters
  // ---------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] defl_cnt_q, defl_cnt_d;
  logic [CNT_W-1:0] ej_cnt_q, ej_cnt_d;

  always_comb begin
    defl_cnt_d = defl_cnt_q;
    ej_cnt_d   = ej_cnt_q;
    if (is_local && ej_full_q && !(&defl_cnt_q)) begin
      defl_cnt_d = defl_cnt_q + CNT_ONE;
    end
    if (pop_en && !(&ej_cnt_q)) begin
      ej_cnt_d = ej_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      defl_cnt_q <= '0;
      ej_cnt_q   <= '0;
    end else begin
      defl_cnt_q <= defl_cnt_d;
      ej_cnt_q   <= ej_cnt_d;
    end
  end

  assign defl_cnt = defl_cnt_q;
  assign ej_cnt   = ej_cnt_q;
`endif

endmodule

// File: tb/tb_flit_eject.sv
// -----------------------------------------------------------------------------
// tb_flit_eject
//   Directed, table-driven bench for flit_eject (DEPTH=4, LOCAL_DEST=3'b010).
//   Each table row is one clock: inputs applied, edge taken, outputs compared
//   1 time unit after the edge. A streaming loop then covers pointer wrap.
//   Counter checks are included when EJECT_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_flit_eject;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] in_flit;
  logic       in_vld;
  logic [9:0] pass_flit;
  logic       pass_vld;
  logic [9:0] ej_flit;
  logic       ej_vld;
  logic       ej_rdy;
  logic       ej_full;
`ifdef EJECT_STATS_EN
  logic [7:0] defl_cnt;
  logic [7:0] ej_cnt;
`endif

  int checks = 0;
  int errors = 0;

  flit_eject dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_flit   (in_flit),
    .in_vld    (in_vld),
    .pass_flit (pass_flit),
    .pass_vld  (pass_vld),
    .ej_flit   (ej_flit),
    .ej_vld    (ej_vld),
    .ej_rdy    (ej_rdy),
    .ej_full   (ej_full)
`ifdef EJECT_STATS_EN
    , .defl_cnt (defl_cnt),
    .ej_cnt    (ej_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  typedef struct {
    logic       rst_n;
    logic       vld;
    logic [9:0] flit;
    logic       rdy;
    logic       e_pvld;
    logic [9:0] e_pflit;
    logic       e_evld;
    logic [9:0] e_eflit;
    logic       ck_eflit;
    logic       e_full;
    logic [7:0] e_defl;
    logic [7:0] e_ejc;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [9:0] f, input logic rd);
    rst_n   = r;
    in_vld  = v;
    in_flit = f;
    ej_rdy  = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rst vld flit    rdy  pvld pflit   evld eflit  ck   full defl ejc
    tbl[0]  = '{1'b0,1'b1,10'h080,1'b0, 1'b0,10'h000, 1'b0,10'h000,1'b1, 1'b0, 8'd0,8'd0}; // reset with local flit
    tbl[1]  = '{1'b0,1'b1,10'h080,1'b0, 1'b0,10'h000, 1'b0,10'h000,1'b1, 1'b0, 8'd0,8'd0};
    tbl[2]  = '{1'b1,1'b1,10'h2C5,1'b0, 1'b1,10'h2C5, 1'b0,10'h000,1'b1, 1'b0, 8'd0,8'd0}; // pass-through
    tbl[3]  = '{1'b1,1'b1,10'h095,1'b0, 1'b0,10'h2C5, 1'b1,10'h095,1'b1, 1'b0, 8'd0,8'd0}; // eject
    tbl[4]  = '{1'b1,1'b0,10'h000,1'b1, 1'b0,10'h2C5, 1'b0,10'h000,1'b0, 1'b0, 8'd0,8'd1}; // pop
    tbl[5]  = '{1'b1,1'b1,10'h081,1'b0, 1'b0,10'h2C5, 1'b1,10'h081,1'b1, 1'b0, 8'd0,8'd1}; // fill
    tbl[6]  = '{1'b1,1'b1,10'h082,1'b0, 1'b0,10'h2C5, 1'b1,10'h081,1'b1, 1'b0, 8'd0,8'd1};
    tbl[7]  = '{1'b1,1'b1,10'h083,1'b0, 1'b0,10'h2C5, 1'b1,10'h081,1'b1, 1'b0, 8'd0,8'd1};
    tbl[8]  = '{1'b1,1'b1,10'h084,1'b0, 1'b0,10'h2C5, 1'b1,10'h081,1'b1, 1'b1, 8'd0,8'd1}; // full
    tbl[9]  = '{1'b1,1'b1,10'h085,1'b0, 1'b1,10'h085, 1'b1,10'h081,1'b1, 1'b1, 8'd1,8'd1}; // deflect
    tbl[10] = '{1'b1,1'b1,10'h086,1'b1, 1'b1,10'h086, 1'b1,10'h082,1'b1, 1'b0, 8'd2,8'd2}; // pop at full, still deflect
    tbl[11] = '{1'b1,1'b0,10'h000,1'b1, 1'b0,10'h086, 1'b1,10'h083,1'b1, 1'b0, 8'd2,8'd3}; // drain
    tbl[12] = '{1'b1,1'b0,10'h000,1'b1, 1'b0,10'h086, 1'b1,10'h084,1'b1, 1'b0, 8'd2,8'd4};
    tbl[13] = '{1'b1,1'b0,10'h000,1'b1, 1'b0,10'h086, 1'b0,10'h000,1'b0, 1'b0, 8'd2,8'd5};
    tbl[14] = '{1'b1,1'b0,10'h095,1'b0, 1'b0,10'h086, 1'b0,10'h000,1'b0, 1'b0, 8'd2,8'd5}; // in_vld=0 ignored
    tbl[15] = '{1'b1,1'b1,10'h2A7,1'b1, 1'b0,10'h086, 1'b1,10'h2A7,1'b1, 1'b0, 8'd2,8'd5}; // rdy while empty: no effect
    tbl[16] = '{1'b1,1'b0,10'h000,1'b1, 1'b0,10'h086, 1'b0,10'h000,1'b0, 1'b0, 8'd2,8'd6};
    tbl[17] = '{1'b1,1'b1,10'h0A0,1'b0, 1'b0,10'h086, 1'b1,10'h0A0,1'b1, 1'b0, 8'd2,8'd6};
    tbl[18] = '{1'b0,1'b1,10'h0A1,1'b0, 1'b0,10'h000, 1'b0,10'h000,1'b1, 1'b0, 8'd0,8'd0}; // reset drops contents
    tbl[19] = '{1'b1,1'b0,10'h000,1'b0, 1'b0,10'h000, 1'b0,10'h000,1'b1, 1'b0, 8'd0,8'd0};

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].rst_n, tbl[i].vld, tbl[i].flit, tbl[i].rdy);
      chk($sformatf("v%0d pass_vld", i),  32'(pass_vld),  32'(tbl[i].e_pvld));
      chk($sformatf("v%0d pass_flit", i), 32'(pass_flit), 32'(tbl[i].e_pflit));
      chk($sformatf("v%0d ej_vld", i),    32'(ej_vld),    32'(tbl[i].e_evld));
      chk($sformatf("v%0d ej_full", i),   32'(ej_full),   32'(tbl[i].e_full));
      if (tbl[i].ck_eflit)
        chk($sformatf("v%0d ej_flit", i), 32'(ej_flit),   32'(tbl[i].e_eflit));
`ifdef EJECT_STATS_EN
      chk($sformatf("v%0d defl_cnt", i),  32'(defl_cnt),  32'(tbl[i].e_defl));
      chk($sformatf("v%0d ej_cnt", i),    32'(ej_cnt),    32'(tbl[i].e_ejc));
`endif
    end

    // Streaming with ej_rdy held high: each flit is at the head one cycle
    // after it is written and popped on the following edge, so pointers wrap
    // several times with the FIFO never above one entry.
    for (int i = 0; i < 20; i++) begin
      logic [9:0] f;
      f = {i[0], 3'b010, 6'(i)};
      step(1'b1, 1'b1, f, 1'b1);
      chk($sformatf("wrap%0d ej_vld", i),   32'(ej_vld),   32'd1);
      chk($sformatf("wrap%0d ej_flit", i),  32'(ej_flit),  32'(f));
      chk($sformatf("wrap%0d pass_vld", i), 32'(pass_vld), 32'd0);
      chk($sformatf("wrap%0d ej_full", i),  32'(ej_full),  32'd0);
    end
    step(1'b1, 1'b0, 10'h000, 1'b1);
    chk("wrap drained ej_vld", 32'(ej_vld), 32'd0);
`ifdef EJECT_STATS_EN
    chk("wrap ej_cnt",   32'(ej_cnt),   32'd20);
    chk("wrap defl_cnt", 32'(defl_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
